yolo_pe_scheduler: RTL and testbench
====================================

YOLO_PE_SCHEDULER -- requirements
Module: yolo_pe_scheduler

Interface
REQ-001 SHALL have parameter DATA_BIT, default 16, meaning the width of every data and parameter word.
REQ-002 SHALL have parameter PE_LATENCY, default 6, meaning the fixed cycle count from PE input sample to PE result.
REQ-003 SHALL have parameter OUT_DEPTH, default 8, meaning the output FIFO entry count (power of 2).
REQ-004 SHALL have parameter CNT_BIT, default 16, meaning the width of the box counters.
REQ-005 SHALL have ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset; one clock, reset asynchronous active-low.
- start  in  1  frame start pulse.
- box_total  in  CNT_BIT  boxes in the frame; sampled on accepted start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- in_valid / in_ready  in / out  1 / 1  raw box handshake.
- in_param  in  DATA_BIT  [11:8] repair, [7:4] grid n, [3:0] grid m.
- in_tx, in_ty, in_tw, in_th  in  DATA_BIT each  raw box terms.
- pe_param  out  DATA_BIT  parameter word to the PE.
- pe_bx0, pe_by0, pe_bw0, pe_bh0  out  DATA_BIT each  PE operands.
- pe_res_x, pe_res_y, pe_res_w, pe_res_h  in  DATA_BIT each  PE results.
- out_valid / out_ready  out / in  1 / 1  decoded box handshake.
- out_x, out_y, out_w, out_h, out_param  out  DATA_BIT each  decoded box and its parameter word.
- issued_cnt  out  CNT_BIT  boxes issued this frame.

Function
REQ-006 SHALL implement FSM IDLE -> RUN on start while IDLE, RUN -> DRAIN when issued_cnt == box_total, DRAIN -> DONE when inflight == 0 and the FIFO is empty, and DONE -> IDLE unconditionally.
REQ-007 SHALL ignore start outside IDLE.
REQ-008 SHALL go IDLE -> DRAIN when box_total == 0, so that done pulses 2 cycles after start.
REQ-009 SHALL assert in_ready = (state == RUN) && (inflight + fifo_count < OUT_DEPTH) && (issued_cnt < box_total), combinationally.
REQ-010 SHALL register the box on in_valid && in_ready into the pe_* outputs, increment issued_cnt, and push a tag {valid, in_param} into a PE_LATENCY-deep delay line.
REQ-011 SHALL hold the pe_* outputs at zero on cycles with no issue (bubble).
REQ-012 SHALL write {pe_res_*, tag param} into the FIFO when the tag emerges from the delay line; this push never overflows because of the credit rule.
REQ-013 SHALL define inflight as the count of valid tags in the delay line; issue and retire in the same cycle leave it unchanged.
REQ-014 SHALL allow a simultaneous FIFO push and pop on the same cycle, leaving the count unchanged.
REQ-015 SHALL wrap the FIFO pointers modulo OUT_DEPTH.
REQ-016 SHALL drive out_valid = FIFO non-empty and out_* = head entry; these outputs are stable while out_valid && !out_ready.
REQ-017 SHALL give an issue-to-out_valid latency of PE_LATENCY+2 cycles with an empty FIFO.
REQ-018 SHALL assert busy in RUN and DRAIN, and done only in DONE.
REQ-019 SHALL hold issued_cnt until the next accepted start, which clears it.

Reset
REQ-020 SHALL clear, while M_AXI_ARESETN is low, the state to IDLE; busy, done, in_ready, out_valid to 0; all pe_*, out_*, issued_cnt, inflight, FIFO pointers, count, and delay-line tags to 0.
REQ-021 SHALL discard in-flight boxes on a reset asserted mid-frame, with no done pulse.

Configuration
REQ-022 SHALL, with YOLO_PE_SCHED_PERF_EN defined, add output stall_cnt [CNT_BIT], which counts RUN cycles with in_valid && !in_ready, saturates at all-ones, clears on accepted start, and resets to 0.
REQ-023 SHALL, without YOLO_PE_SCHED_PERF_EN, have no stall_cnt port or logic.

Structure
REQ-024 SHALL place the FSM state enum and the in_param field positions (repair 11:8, n 7:4, m 3:0) in shared package yolo_pe_pkg.
REQ-025 SHALL implement the FIFO as a single sub-module yolo_pe_out_fifo (parameterised width/depth, count output).

Verification
REQ-026 SHALL cover: box_total=3, in_valid held 1, out_ready=1 -> 3 consecutive issues, out_valid at cycles 8, 9, 10 after first issue, done one cycle after last pop.
REQ-027 SHALL cover: box_total=20, out_ready=0 -> exactly 8 issues, then in_ready=0; after out_ready=1 all 20 emerge in order, out_param matching input order.
REQ-028 SHALL cover: box_total=0 start -> done pulse 2 cycles later, no pe issue.
REQ-029 SHALL cover: start pulsed again during RUN -> ignored; issued_cnt continues, box_total unchanged.
REQ-030 SHALL cover: M_AXI_ARESETN low mid-frame with 4 in flight -> all outputs 0 immediately, no out_valid or done afterward, next start behaves normally.
REQ-031 SHALL cover: with YOLO_PE_SCHED_PERF_EN and the REQ-027 stimulus -> stall_cnt equals in_valid-high RUN cycles with in_ready=0.

Source files
------------

// File: rtl/yolo_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : yolo_pe_pkg
// Brief    : Shared types for the YOLO PE scheduler: FSM state encoding and
//            the bit positions of the fields inside the box parameter word.
// Revision : 1.0 - initial release
// ============================================================================
package yolo_pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Field positions inside in_param / out_param
    localparam int unsigned c_REPAIR_MSB = 11;
    localparam int unsigned c_REPAIR_LSB = 8;
    localparam int unsigned c_GRID_N_MSB = 7;
    localparam int unsigned c_GRID_N_LSB = 4;
    localparam int unsigned c_GRID_M_MSB = 3;
    localparam int unsigned c_GRID_M_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/yolo_pe_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : yolo_pe_out_fifo
// Brief    : Power-of-two synchronous FIFO holding decoded boxes, with
//            first-word fall-through head and an occupancy count output.
// Revision : 1.0 - initial release
// ============================================================================
module yolo_pe_out_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    import yolo_pe_pkg::*;

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && (r_count != c_FULL);
    assign w_pop  = i_pop && (r_count != '0);

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/yolo_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : yolo_pe_scheduler
// Brief    : Issues raw boxes to a fixed-latency PE under a credit limit and
//            collects the results, in order, into an output FIFO.
//            Optional: YOLO_PE_SCHED_PERF_EN adds the stall_cnt counter.
// Revision : 1.0 - initial release
// ============================================================================
module yolo_pe_scheduler #(
    parameter int DATA_BIT   = 16,
    parameter int PE_LATENCY = 6,
    parameter int OUT_DEPTH  = 8,
    parameter int CNT_BIT    = 16
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                start,
    input  logic [CNT_BIT-1:0]  box_total,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] in_param,
    input  logic [DATA_BIT-1:0] in_tx,
    input  logic [DATA_BIT-1:0] in_ty,
    input  logic [DATA_BIT-1:0] in_tw,
    input  logic [DATA_BIT-1:0] in_th,
    output logic [DATA_BIT-1:0] pe_param,
    output logic [DATA_BIT-1:0] pe_bx0,
    output logic [DATA_BIT-1:0] pe_by0,
    output logic [DATA_BIT-1:0] pe_bw0,
    output logic [DATA_BIT-1:0] pe_bh0,
    input  logic [DATA_BIT-1:0] pe_res_x,
    input  logic [DATA_BIT-1:0] pe_res_y,
    input  logic [DATA_BIT-1:0] pe_res_w,
    input  logic [DATA_BIT-1:0] pe_res_h,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_x,
    output logic [DATA_BIT-1:0] out_y,
    output logic [DATA_BIT-1:0] out_w,
    output logic [DATA_BIT-1:0] out_h,
    output logic [DATA_BIT-1:0] out_param,
    output logic [CNT_BIT-1:0]  issued_cnt
`ifdef YOLO_PE_SCHED_PERF_EN
    ,
    output logic [CNT_BIT-1:0]  stall_cnt
`endif
);
    import yolo_pe_pkg::*;

    localparam int c_CNT_W = $clog2(OUT_DEPTH) + 1;

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [CNT_BIT-1:0]    r_box_total;
    logic [CNT_BIT-1:0]    r_issued;
    logic [c_CNT_W-1:0]    r_inflight;
    logic [DATA_BIT:0]     r_pe_tag;
    logic [DATA_BIT:0]     r_tag_dl [PE_LATENCY];
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic                  w_fifo_empty;
    logic [5*DATA_BIT-1:0] w_head;
    logic                  w_start_acc;
    logic                  w_issue;
    logic                  w_retire;
    logic                  w_credit_ok;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_issue     = in_valid && in_ready;
    assign w_retire    = r_tag_dl[PE_LATENCY-1][DATA_BIT];
    // Every issued box already owns a FIFO slot, so the retire push cannot overflow
    assign w_credit_ok = (int'(r_inflight) + int'(w_fifo_count)) < OUT_DEPTH;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (box_total == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = w_credit_ok && (r_issued < r_box_total);
                if (r_issued == r_box_total) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if ((r_inflight == '0) && w_fifo_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state     <= ST_IDLE;
            r_box_total <= '0;
            r_issued    <= '0;
            r_inflight  <= '0;
            r_pe_tag    <= '0;
            pe_param    <= '0;
            pe_bx0      <= '0;
            pe_by0      <= '0;
            pe_bw0      <= '0;
            pe_bh0      <= '0;
            for (int i = 0; i < PE_LATENCY; i++) begin
                r_tag_dl[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_box_total <= box_total;
                r_issued    <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end
            // Operands are zero on bubble cycles
            pe_param <= w_issue ? in_param : '0;
            pe_bx0   <= w_issue ? in_tx    : '0;
            pe_by0   <= w_issue ? in_ty    : '0;
            pe_bw0   <= w_issue ? in_tw    : '0;
            pe_bh0   <= w_issue ? in_th    : '0;
            r_pe_tag <= w_issue ? {1'b1, in_param} : '0;
            r_tag_dl[0] <= r_pe_tag;
            for (int i = 1; i < PE_LATENCY; i++) begin
                r_tag_dl[i] <= r_tag_dl[i-1];
            end
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    yolo_pe_out_fifo #(
        .WIDTH (5 * DATA_BIT),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .i_push  (w_retire),
        .i_data  ({pe_res_x, pe_res_y, pe_res_w, pe_res_h,
                   r_tag_dl[PE_LATENCY-1][DATA_BIT-1:0]}),
        .i_pop   (out_valid && out_ready),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign {out_x, out_y, out_w, out_h, out_param} = w_head;
    assign issued_cnt = r_issued;

`ifdef YOLO_PE_SCHED_PERF_EN
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            stall_cnt <= '0;
        end else if (w_start_acc) begin
            stall_cnt <= '0;
        end else if ((r_state == ST_RUN) && in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_yolo_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_yolo_pe_scheduler
// Brief    : Scoreboard bench for yolo_pe_scheduler with a fixed-latency PE model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yolo_pe_scheduler;
    localparam int DW     = 16;
    localparam int PE_LAT = 6;
    localparam int DEPTH  = 8;
    localparam int CW     = 16;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] w;
        logic [DW-1:0] h;
        logic [DW-1:0] p;
    } box_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] box_total;
    logic          busy, done, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_param, in_tx, in_ty, in_tw, in_th;
    logic [DW-1:0] pe_param, pe_bx0, pe_by0, pe_bw0, pe_bh0;
    logic [DW-1:0] pe_res_x, pe_res_y, pe_res_w, pe_res_h;
    logic [DW-1:0] out_x, out_y, out_w, out_h, out_param;
    logic [CW-1:0] issued_cnt;
`ifdef YOLO_PE_SCHED_PERF_EN
    logic [CW-1:0] stall_cnt;
`endif

    box_t sb_q[$];
    int   acc_cyc[$];
    int   pop_cyc[$];
    int   done_cyc[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_pop  = 0;
    int   cyc    = 0;
    int   acc;
    int   s_cyc;
    int   prev_done;
    int   prev_pop;

    yolo_pe_scheduler #(
        .DATA_BIT   (DW),
        .PE_LATENCY (PE_LAT),
        .OUT_DEPTH  (DEPTH),
        .CNT_BIT    (CW)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .box_total     (box_total),
        .busy          (busy),
        .done          (done),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_param      (in_param),
        .in_tx         (in_tx),
        .in_ty         (in_ty),
        .in_tw         (in_tw),
        .in_th         (in_th),
        .pe_param      (pe_param),
        .pe_bx0        (pe_bx0),
        .pe_by0        (pe_by0),
        .pe_bw0        (pe_bw0),
        .pe_bh0        (pe_bh0),
        .pe_res_x      (pe_res_x),
        .pe_res_y      (pe_res_y),
        .pe_res_w      (pe_res_w),
        .pe_res_h      (pe_res_h),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_w         (out_w),
        .out_h         (out_h),
        .out_param     (out_param),
        .issued_cnt    (issued_cnt)
`ifdef YOLO_PE_SCHED_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PE model: samples operands each edge, result appears PE_LAT edges later
    logic [4*DW-1:0] pe_pipe [PE_LAT];
    always @(posedge clk) begin
        pe_pipe[0] <= {pe_bx0 + 16'd3, pe_by0 + 16'd5, pe_bw0 << 1, pe_bh0 - 16'd1};
        for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
    assign {pe_res_x, pe_res_y, pe_res_w, pe_res_h} = pe_pipe[PE_LAT-1];

    function automatic box_t model(input int idx);
        box_t r;
        r.x = 16'h1000 + 16'(idx) + 16'd3;
        r.y = 16'h2000 + 16'(idx) + 16'd5;
        r.w = (16'h0040 + 16'(idx)) << 1;
        r.h = 16'h0080 + 16'(idx) - 16'd1;
        r.p = 16'h0A00 + 16'(idx);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output
    always @(negedge clk) begin
        box_t e;
        box_t g;
        if (rst_n) begin
            if (done) begin
                n_done++;
                done_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                n_pop++;
                g = {out_x, out_y, out_w, out_h, out_param};
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pop: got %h, required no output", g);
                end else begin
                    e = sb_q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL box_data: got %h, required %h", g, e);
                    end
                end
            end
        end
    end

    task automatic do_start(input int total);
        @(posedge clk); #1;
        start     = 1'b1;
        box_total = CW'(total);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic drive_boxes(input int n, input int base, input int budget, output int nacc);
        nacc = 0;
        for (int c = 0; c < budget && nacc < n; c++) begin
            in_valid = 1'b1;
            in_tx    = 16'h1000 + 16'(base + nacc);
            in_ty    = 16'h2000 + 16'(base + nacc);
            in_tw    = 16'h0040 + 16'(base + nacc);
            in_th    = 16'h0080 + 16'(base + nacc);
            in_param = 16'h0A00 + 16'(base + nacc);
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(base + nacc));
                acc_cyc.push_back(cyc);
                nacc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int k = 0;
        while (n_done == prev && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        n_chk++;
        if (n_done == prev) begin
            n_fail++;
            $display("FAIL %s: got no done pulse in %0d cycles, required one", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; box_total = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_param = '0; in_tx = '0; in_ty = '0; in_tw = '0; in_th = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_pe_bx0", pe_bx0, 0);
`ifdef YOLO_PE_SCHED_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1'b1;

        // Three back-to-back issues, latency and done timing
        out_ready = 1'b1;
        acc_cyc.delete(); pop_cyc.delete(); done_cyc.delete();
        prev_done = n_done;
        do_start(3);
        drive_boxes(3, 0, 20, acc);
        chk("t1_accepted", acc, 3);
        wait_done(prev_done, 60, "t1_done");
        chk("t1_issue1_gap", acc_cyc[1] - acc_cyc[0], 1);
        chk("t1_issue2_gap", acc_cyc[2] - acc_cyc[0], 2);
        chk("t1_out0_latency", pop_cyc[0] - acc_cyc[0], 8);
        chk("t1_out1_latency", pop_cyc[1] - acc_cyc[0], 9);
        chk("t1_out2_latency", pop_cyc[2] - acc_cyc[0], 10);
        // FIFO empties at the last pop edge; the FSM reaches DONE on the following edge
        chk("t1_done_after_pop", done_cyc[done_cyc.size()-1] - pop_cyc[2], 2);
        chk("t1_issued_cnt", issued_cnt, 3);
        @(negedge clk); #1;
        chk("t1_done_pulse_width", done, 0);

        // Backpressure: 20 boxes, output blocked until credits run out
        out_ready = 1'b0;
        prev_done = n_done;
        prev_pop  = n_pop;
        do_start(20);
        fork
            drive_boxes(20, 16, 300, acc);
            begin
                repeat (30) @(negedge clk);
                chk("t2_issued_blocked", issued_cnt, 8);
                chk("t2_in_ready_low", in_ready, 0);
                chk("t2_out_valid_high", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("t2_accepted", acc, 20);
        wait_done(prev_done, 200, "t2_done");
        chk("t2_pops", n_pop - prev_pop, 20);
        chk("t2_sb_empty", sb_q.size(), 0);
`ifdef YOLO_PE_SCHED_PERF_EN
        // Stalls: 23 cycles while the first 8 wait plus 1 when the FIFO refills
        chk("t2_stall_cnt", stall_cnt, 24);
`endif

        // Empty frame
        prev_done = n_done;
        prev_pop  = n_pop;
        @(posedge clk); #1;
        start = 1'b1; box_total = '0; s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t3_busy", busy, 1);
        chk("t3_in_ready", in_ready, 0);
        wait_done(prev_done, 10, "t3_done");
        chk("t3_done_cycle", done_cyc[done_cyc.size()-1] - s_cyc, 2);
        chk("t3_issued", issued_cnt, 0);
        chk("t3_pops", n_pop - prev_pop, 0);

        // Start during RUN must be ignored
        prev_done = n_done;
        prev_pop  = n_pop;
        do_start(5);
        fork
            drive_boxes(9, 64, 40, acc);
            begin
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                start = 1'b1; box_total = 16'd9;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        chk("t4_accepted", acc, 5);
        chk("t4_issued", issued_cnt, 5);
        wait_done(prev_done, 40, "t4_done");
        chk("t4_pops", n_pop - prev_pop, 5);

        // Reset mid-frame with 4 boxes in flight
        do_start(10);
        drive_boxes(4, 100, 20, acc);
        chk("t5_accepted", acc, 4);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_issued", issued_cnt, 0);
        chk("t5_rst_out_x", out_x, 0);
        chk("t5_rst_out_param", out_param, 0);
        sb_q.delete();
        prev_done = n_done;
        prev_pop  = n_pop;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_done_after_rst", n_done - prev_done, 0);
        chk("t5_no_out_after_rst", n_pop - prev_pop, 0);
        do_start(2);
        drive_boxes(2, 200, 20, acc);
        chk("t5_next_accepted", acc, 2);
        wait_done(prev_done, 40, "t5_next_done");
        chk("t5_next_pops", n_pop - prev_pop, 2);

        chk("sb_empty_end", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
